apb_slave_mem: RTL and testbench
================================

Name: apb_slave_mem

Overview:
- APB completer (slave) memory model for the far end of the AHB-to-APB bridge.
- Accepts APB setup/access phases from the bridge's APB master side.
- Backs them with a DEPTH-word register array; inserts programmable wait states via pready; flags decode errors on pslverr.
- Used as the bridge's peripheral in system-level benches and as a reusable synthesizable test peripheral.

Parameters:
- DEPTH, 16, number of 32-bit words; power of two, 2..256.
- BASE_ADDR, 32'h8000_0000, byte address of word 0; aligned to 4*DEPTH.
- WAIT_CYCLES, 2, wait states per access when SLAVE_WAIT_STATE_EN is defined; 0..15.

Ports:
- hclk  input  1  system clock; all logic on rising edge.
- hreset  input  1  synchronous, active-high reset.
- psel  input  1  slave select from bridge.
- penable  input  1  access-phase strobe.
- pwrite  input  1  1 = write, 0 = read.
- paddr  input  32  byte address.
- pwdata  input  32  write data.
- prdata  output  32  read data, valid only while pready=1.
- pready  output  1  transfer-complete handshake.
- pslverr  output  1  error response, valid only while pready=1.

Behaviour:
- Clock and reset: one clock (hclk); reset hreset is synchronous and active-high.
- Reset values (hreset=1 at a rising edge):
  - State IDLE.
  - pready=0, pslverr=0, prdata=0.
  - Wait counter cleared; all memory words cleared to 0.
- Outputs: all registered; no combinational path from inputs to outputs.
- Decode: access is valid iff BASE_ADDR <= paddr < BASE_ADDR+4*DEPTH and paddr[1:0]==0. Word index = (paddr-BASE_ADDR)>>2, width $clog2(DEPTH).
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - On psel=1 & penable=0 (setup cycle): capture paddr, pwrite, pwdata and the decode result; load counter with W (W = WAIT_CYCLES, or 0 without the macro); go ACCESS.
  - If W==0, also set pready=1 for the next cycle.
  - penable=1 without a preceding setup is ignored: stay IDLE, pready stays 0.
- ACCESS (psel=1, penable=1 expected):
  - pready=0 while counter>0; counter decrements each cycle.
  - When counter reaches 1, set pready=1 for the following cycle.
  - Completion edge = rising edge where pready=1 & psel=1 & penable=1.
    - Write: mem[index] <= captured pwdata, only if decode is valid.
    - Next state DONE; pready and pslverr cleared.
  - prdata presented in the pready cycle:
    - valid read: mem[index];
    - error: 0;
    - write: 0.
  - pslverr=1 in the pready cycle iff decode is invalid. An invalid write never modifies memory.
  - psel drops or penable drops before completion: abort, no write, pready=0, return to IDLE.
- DONE:
  - Single-cycle state; behaves exactly as IDLE, so a new setup in this cycle is accepted.
  - Back-to-back transfers therefore cost setup + (W+1) access cycles each, with no bubble.
- Latency:
  - W=0: setup T0, pready=1 in T1.
  - W=N: pready low in T1..TN, high in T(N+1).
- Signals presented in setup are the captured values; changes to paddr/pwdata during access are ignored.
- Reset mid-transfer: abort immediately; pending write discarded; all reset values apply.

Optional Feature:
- Macro: SLAVE_WAIT_STATE_EN.
- Defined: WAIT_CYCLES wait states are inserted per access as described.
- Undefined: W forced to 0; WAIT_CYCLES parameter ignored; counter logic removed; every transfer completes in the first access cycle.

Decomposition:
- Package apb_slave_pkg:
  - state enum (IDLE, ACCESS, DONE);
  - APB_ADDR_W=32, APB_DATA_W=32;
  - CNT_W=4.
- Sub-module apb_wait_counter: loadable down-counter with a "last" flag driving pready generation. Instantiated only under SLAVE_WAIT_STATE_EN.

Test Plan:
- Reset behaviour: hreset=1 for 2 cycles, then read 0x8000_0008 -> prdata=0, pslverr=0.
- Write then read: write 0xDEAD_BEEF to 0x8000_0004, then read 0x8000_0004.
  - Read returns 0xDEAD_BEEF.
  - With macro and WAIT_CYCLES=2, pready rises exactly 3 cycles after setup.
- Decode errors:
  - Write 0x1234_5678 to 0x8000_0040 (DEPTH=16) -> pslverr=1 in the pready cycle, memory unchanged.
  - Read 0x8000_0002 -> pslverr=1, prdata=0.
- Back-to-back with macro off: 4 writes to 0x8000_0000..0x8000_000C with data 1..4, each setup issued in the cycle after completion.
  - Each pready appears 1 cycle after setup.
  - Readback returns 1..4.
- Abort: drop psel in the 2nd access cycle of a write (WAIT_CYCLES=2) -> no pready, target word keeps its old value, next setup accepted normally.
- Reset mid-transfer: assert hreset during the access phase of a write to 0x8000_0000 -> pready=0 next cycle, word reads 0 afterwards.

Source files
------------

// File: rtl/apb_slave_pkg.sv
// apb_slave_pkg: shared types and widths for the APB completer memory.
//   apb_state_e : transfer FSM state (IDLE, ACCESS, DONE)
//   APB_ADDR_W  : APB address width
//   APB_DATA_W  : APB data width
//   CNT_W       : wait-state counter width (enough for 0..15 wait states)
package apb_slave_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_wait_counter.sv
// apb_wait_counter: loadable down-counter that times the wait states of one
// APB access. Loaded with the wait-state count at the setup edge, it counts
// down once per stalled access cycle. last_o is high while the count is 1,
// which is the cycle in which pready must be scheduled for the next cycle.
// Ports:
//   clk_i      : clock, rising edge
//   rst_i      : synchronous active-high reset (clears the count)
//   load_i     : load load_val_i this cycle (takes priority over dec_i)
//   load_val_i : value to load
//   dec_i      : decrement this cycle (saturates at 0)
//   last_o     : count equals 1
module apb_wait_counter
  import apb_slave_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             last_o
);

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB completer backed by a DEPTH-word register array.
// Optional wait states are enabled by defining the macro SLAVE_WAIT_STATE_EN;
// with it undefined every transfer completes in its first access cycle and
// WAIT_CYCLES has no effect.
//
// Handshake: a transfer starts with a setup cycle (psel=1, penable=0), in
// which address, direction, write data and the decode result are captured.
// It completes on the rising edge where psel=1, penable=1 and pready=1.
// Dropping psel or penable before that edge aborts the transfer with no
// side effects. prdata and pslverr are meaningful only while pready=1.
//
// Ports:
//   hclk    : clock, rising edge
//   hreset  : synchronous active-high reset
//   psel    : completer select
//   penable : access-phase strobe
//   pwrite  : 1 = write, 0 = read
//   paddr   : byte address
//   pwdata  : write data
//   prdata  : read data (registered)
//   pready  : transfer complete (registered)
//   pslverr : decode error response (registered)
module apb_slave_mem
  import apb_slave_pkg::*;
#(
  parameter int unsigned           DEPTH       = 16,
  parameter logic [APB_ADDR_W-1:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned           WAIT_CYCLES = 2
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [APB_ADDR_W-1:0] paddr,
  input  logic [APB_DATA_W-1:0] pwdata,
  output logic [APB_DATA_W-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr
);

  localparam int unsigned           IDX_W = $clog2(DEPTH);
  localparam logic [APB_ADDR_W-1:0] SPAN  = APB_ADDR_W'(4 * DEPTH);

  // Elaboration-time parameter sanity checks.
  if ((DEPTH < 2) || (DEPTH > 256) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("apb_slave_mem: DEPTH must be a power of two in 2..256");
  end
  if (WAIT_CYCLES > 15) begin : g_bad_wait
    $error("apb_slave_mem: WAIT_CYCLES must be in 0..15");
  end
  if ((BASE_ADDR & (SPAN - 1'b1)) != '0) begin : g_bad_base
    $error("apb_slave_mem: BASE_ADDR must be aligned to 4*DEPTH");
  end

  // FSM state and registered outputs; state_q is the observable FSM state.
  apb_state_e            state_q;
  logic                  pready_q;
  logic                  pslverr_q;
  logic [APB_DATA_W-1:0] prdata_q;

  // Transfer context captured in the setup cycle.
  logic                  write_q;
  logic                  valid_q;
  logic [IDX_W-1:0]      idx_q;
  logic [APB_DATA_W-1:0] wdata_q;

  logic [APB_DATA_W-1:0] mem_q [DEPTH];

  // Decode of the live address. Because BASE_ADDR is aligned to the window
  // size, the wrapped subtraction is below SPAN exactly when paddr lies in
  // [BASE_ADDR, BASE_ADDR + SPAN), so one compare checks both bounds.
  logic [APB_ADDR_W-1:0] offset;
  logic                  dec_valid;
  logic [IDX_W-1:0]      dec_idx;

  assign offset    = paddr - BASE_ADDR;
  assign dec_valid = (offset < SPAN) && (paddr[1:0] == 2'b00);
  assign dec_idx   = offset[IDX_W+1:2];

  logic setup_accept;
  logic access_held;
  logic mem_we;
  logic wait_last;

  assign setup_accept = (state_q != ACCESS) && psel && !penable;
  assign access_held  = psel && penable;
  assign mem_we       = (state_q == ACCESS) && access_held && pready_q &&
                        write_q && valid_q;

  // Read data for the pready cycle: zero for writes and decode errors.
  // rdata_setup serves the zero-wait case, where pready is scheduled at the
  // setup edge before the captured index exists.
  logic [APB_DATA_W-1:0] rdata_setup;
  logic [APB_DATA_W-1:0] rdata_cap;

  assign rdata_setup = (dec_valid && !pwrite) ? mem_q[dec_idx] : '0;
  assign rdata_cap   = (valid_q && !write_q) ? mem_q[idx_q]   : '0;

`ifdef SLAVE_WAIT_STATE_EN
  localparam bit               W_ZERO = (WAIT_CYCLES == 0);
  localparam logic [CNT_W-1:0] W_LOAD = CNT_W'(WAIT_CYCLES);

  logic cnt_dec;
  assign cnt_dec = (state_q == ACCESS) && access_held && !pready_q;

  apb_wait_counter u_wait_counter (
    .clk_i      (hclk),
    .rst_i      (hreset),
    .load_i     (setup_accept),
    .load_val_i (W_LOAD),
    .dec_i      (cnt_dec),
    .last_o     (wait_last)
  );
`else
  localparam bit W_ZERO = 1'b1;
  // Without wait states pready is always scheduled at the setup edge, so a
  // stalled access cycle never occurs.
  assign wait_last = 1'b1;
`endif

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q   <= IDLE;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      write_q   <= 1'b0;
      valid_q   <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
    end else begin
      unique case (state_q)
        // DONE behaves as IDLE so back-to-back setups are accepted.
        IDLE, DONE: begin
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
          prdata_q  <= '0;
          if (setup_accept) begin
            state_q <= ACCESS;
            write_q <= pwrite;
            valid_q <= dec_valid;
            idx_q   <= dec_idx;
            wdata_q <= pwdata;
            if (W_ZERO) begin
              pready_q  <= 1'b1;
              pslverr_q <= !dec_valid;
              prdata_q  <= rdata_setup;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        ACCESS: begin
          if (!access_held) begin
            // Abort: requester withdrew before completion.
            state_q   <= IDLE;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
          end else if (pready_q) begin
            // Completion edge; the memory write happens in the array block.
            state_q   <= DONE;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
          end else if (wait_last) begin
            pready_q  <= 1'b1;
            pslverr_q <= !valid_q;
            prdata_q  <= rdata_cap;
          end
        end
        default: begin
          state_q   <= IDLE;
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
          prdata_q  <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign prdata  = prdata_q;
  assign pready  = pready_q;
  assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// tb_apb_slave_mem: self-checking bench for apb_slave_mem (DEPTH=16,
// BASE_ADDR=0x8000_0000, WAIT_CYCLES=2). Expected wait states follow the
// SLAVE_WAIT_STATE_EN macro of the build. Expected read data and error
// responses come from a reference memory in the bench and are queued when
// a transfer is issued, then popped when pready is observed.
module tb_apb_slave_mem;

  localparam int          DEPTH       = 16;
  localparam logic [31:0] BASE        = 32'h8000_0000;
  localparam int          WAIT_CYCLES = 2;
`ifdef SLAVE_WAIT_STATE_EN
  localparam int W = WAIT_CYCLES;
`else
  localparam int W = 0;
`endif
  localparam int TIMEOUT = 40;

  logic        hclk    = 1'b0;
  logic        hreset  = 1'b1;
  logic        psel    = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite  = 1'b0;
  logic [31:0] paddr   = '0;
  logic [31:0] pwdata  = '0;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int checks = 0;
  int errors = 0;

  // Scoreboard entry: {pslverr, prdata}
  logic [32:0] exp_q[$];
  logic [31:0] model_mem [DEPTH];

  apb_slave_mem #(
    .DEPTH       (DEPTH),
    .BASE_ADDR   (BASE),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) dut (
    .hclk    (hclk),
    .hreset  (hreset),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr)
  );

  // ---------------- clock / reset ----------------
  always #5 hclk = ~hclk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic bit addr_ok(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'(4 * DEPTH)) && (a[1:0] == 2'b00);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
  endtask

  task automatic sb_push(input bit wr, input logic [31:0] addr, input logic [31:0] data);
    int idx;
    if (!addr_ok(addr)) begin
      exp_q.push_back({1'b1, 32'h0});
    end else begin
      idx = int'((addr - BASE) >> 2);
      if (wr) begin
        model_mem[idx] = data;
        exp_q.push_back({1'b0, 32'h0});
      end else begin
        exp_q.push_back({1'b0, model_mem[idx]});
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    psel    = 1'b0;
    penable = 1'b0;
    repeat (n) begin
      @(posedge hclk); #1;
    end
  endtask

  // Full transfer: setup, then access until pready; checks latency and the
  // scoreboard entry. Returns #1 after the completion edge with the bus idle.
  task automatic apb_xfer(input bit wr, input logic [31:0] addr,
                          input logic [31:0] data, input string name);
    int          cyc;
    bit          done;
    logic [32:0] exp;
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = data;
    sb_push(wr, addr, data);
    @(posedge hclk); #1;
    penable = 1'b1;
    // Bus values after setup must be ignored by the completer.
    paddr   = $urandom;
    pwdata  = $urandom;
    pwrite  = ~wr;
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < TIMEOUT) begin
      @(negedge hclk);
      cyc++;
      if (pready === 1'b1) begin
        done = 1'b1;
        checks++;
        if (cyc != W + 1) begin
          errors++;
          $display("FAIL %s latency: pready after %0d access cycles, expected %0d", name, cyc, W + 1);
        end
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL %s: pready with no expected entry queued", name);
        end else begin
          exp = exp_q.pop_front();
          checks++;
          if (prdata !== exp[31:0]) begin
            errors++;
            $display("FAIL %s prdata: got %h expected %h", name, prdata, exp[31:0]);
          end
          checks++;
          if (pslverr !== exp[32]) begin
            errors++;
            $display("FAIL %s pslverr: got %b expected %b", name, pslverr, exp[32]);
          end
        end
      end
      @(posedge hclk); #1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: no pready within %0d cycles, expected %0d", name, TIMEOUT, W + 1);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end
    psel    = 1'b0;
    penable = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    hreset  = 1'b1;
    psel    = 1'b0;
    penable = 1'b0;
    repeat (2) begin
      @(posedge hclk); #1;
    end
    @(negedge hclk);
    checks++;
    if (pready !== 1'b0) begin errors++; $display("FAIL reset pready: got %b expected 0", pready); end
    checks++;
    if (pslverr !== 1'b0) begin errors++; $display("FAIL reset pslverr: got %b expected 0", pslverr); end
    checks++;
    if (prdata !== 32'h0) begin errors++; $display("FAIL reset prdata: got %h expected 0", prdata); end
    @(posedge hclk); #1;
    hreset = 1'b0;
    model_clear();
    apb_xfer(1'b0, 32'h8000_0008, 32'h0, "reset_read");
    idle(1);
  endtask

  task automatic test_stray_enable();
    psel    = 1'b1;
    penable = 1'b1;
    pwrite  = 1'b1;
    paddr   = 32'h8000_0010;
    pwdata  = 32'h5555_AAAA;
    for (int i = 0; i < 3; i++) begin
      @(negedge hclk);
      checks++;
      if (pready !== 1'b0) begin
        errors++;
        $display("FAIL stray_enable cycle %0d: pready=%b expected 0", i, pready);
      end
      @(posedge hclk); #1;
    end
    idle(1);
    apb_xfer(1'b0, 32'h8000_0010, 32'h0, "stray_enable_read");
    idle(1);
  endtask

  task automatic test_write_read();
    apb_xfer(1'b1, 32'h8000_0004, 32'hDEAD_BEEF, "wr_deadbeef");
    idle(1);
    apb_xfer(1'b0, 32'h8000_0004, 32'h0, "rd_deadbeef");
    idle(1);
  endtask

  task automatic test_decode_err();
    apb_xfer(1'b1, 32'h8000_0040, 32'h1234_5678, "wr_out_of_range");
    idle(1);
    apb_xfer(1'b0, 32'h8000_0000, 32'h0, "rd_word0_untouched");
    apb_xfer(1'b0, 32'h8000_003C, 32'h0, "rd_word15_untouched");
    idle(1);
    apb_xfer(1'b0, 32'h8000_0002, 32'h0, "rd_misaligned");
    apb_xfer(1'b1, 32'h8000_0005, 32'h7777_7777, "wr_misaligned");
    apb_xfer(1'b0, 32'h8000_0004, 32'h0, "rd_after_misaligned_wr");
    apb_xfer(1'b0, 32'h7FFF_FFFC, 32'h0, "rd_below_base");
    idle(1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      apb_xfer(1'b1, BASE + 32'(4 * i), 32'(i + 1), $sformatf("b2b_wr%0d", i));
    end
    for (int i = 0; i < 4; i++) begin
      apb_xfer(1'b0, BASE + 32'(4 * i), 32'h0, $sformatf("b2b_rd%0d", i));
    end
    idle(1);
  endtask

  task automatic test_random();
    bit          wr;
    logic [31:0] a;
    for (int i = 0; i < 24; i++) begin
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) a = BASE + 32'($urandom_range(0, 4 * DEPTH + 7));
      else a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
      apb_xfer(wr, a, $urandom, $sformatf("rand%0d", i));
      idle($urandom_range(0, 1));
    end
    idle(1);
  endtask

  task automatic test_abort();
    int          ab;
    logic [31:0] a = 32'h8000_0008;
    apb_xfer(1'b1, a, 32'hA5A5_A5A5, "abort_pre_wr");
    idle(1);
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = a;
    pwdata  = 32'hFFFF_0000;
    @(posedge hclk); #1;
    penable = 1'b1;
    // Drop psel in the second access cycle when there are wait states to
    // span it, otherwise in the only access cycle.
    ab = (W >= 2) ? 2 : 1;
    for (int t = 1; t < ab; t++) begin
      @(negedge hclk);
      checks++;
      if (pready !== 1'b0) begin
        errors++;
        $display("FAIL abort_wait cycle %0d: pready=%b expected 0", t, pready);
      end
      @(posedge hclk); #1;
    end
    psel = 1'b0;
    @(posedge hclk); #1;
    penable = 1'b0;
    for (int t = 0; t < 2; t++) begin
      @(negedge hclk);
      checks++;
      if (pready !== 1'b0) begin
        errors++;
        $display("FAIL abort_no_pready %0d: pready=%b expected 0", t, pready);
      end
      @(posedge hclk); #1;
    end
    apb_xfer(1'b0, a, 32'h0, "abort_readback");
    idle(1);
  endtask

  task automatic test_reset_mid();
    apb_xfer(1'b1, BASE, 32'h1111_2222, "rst_mid_pre_wr");
    idle(1);
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = BASE;
    pwdata  = 32'hCAFE_F00D;
    @(posedge hclk); #1;
    penable = 1'b1;
    hreset  = 1'b1;
    @(posedge hclk); #1;
    hreset  = 1'b0;
    psel    = 1'b0;
    penable = 1'b0;
    model_clear();
    @(negedge hclk);
    checks++;
    if (pready !== 1'b0) begin errors++; $display("FAIL rst_mid pready: got %b expected 0", pready); end
    checks++;
    if (pslverr !== 1'b0) begin errors++; $display("FAIL rst_mid pslverr: got %b expected 0", pslverr); end
    @(posedge hclk); #1;
    apb_xfer(1'b0, BASE, 32'h0, "rst_mid_rd_word0");
    apb_xfer(1'b0, BASE + 32'd4, 32'h0, "rst_mid_rd_word1");
    idle(1);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_stray_enable();
    test_write_read();
    test_decode_err();
    test_back_to_back();
    test_random();
    test_abort();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
